// File: rtl/testdrive_axi4_lite_reg_bank_pkg.sv
// Shared constants for the testdrive AXI4-Lite register bank.
// Contents:
//   - AXI response codes (OKAY, SLVERR).
//   - Write and read FSM state encodings.
package testdrive_axi4_lite_reg_bank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE      = 2'd0;
  localparam w_state_t W_HAVE_ADDR = 2'd1;
  localparam w_state_t W_HAVE_DATA = 2'd2;
  localparam w_state_t W_RESP      = 2'd3;

  typedef logic [0:0] r_state_t;
  localparam r_state_t R_IDLE = 1'b0;
  localparam r_state_t R_DATA = 1'b1;

endpackage

// File: rtl/testdrive_axi4_lite_reg_bank.sv
// AXI4-Lite slave register bank: C_REG_COUNT x 32-bit registers with
// byte-strobe writes, flat REG_OUT bus and a one-cycle REG_WE pulse per write.
// Ports:
//   CLK, RST (async, active-high)
//   AW/W/B channels: write address, data+strobes, response
//   AR/R channels  : read address, data+response
//   REG_OUT        : register i at [32i+31:32i]
//   REG_WE         : bit i pulses in the cycle after register i is written
// Config macro: TESTDRIVE_AXIL_REG_BANK_SLVERR_EN makes out-of-range accesses
// answer SLVERR instead of OKAY.
module testdrive_axi4_lite_reg_bank
  import testdrive_axi4_lite_reg_bank_pkg::*;
#(
  parameter int unsigned C_ADDR_BITS = 10,
  parameter int unsigned C_REG_COUNT = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [C_ADDR_BITS-1:0]     AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [31:0]                WDATA,
  input  logic [3:0]                 WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [C_ADDR_BITS-1:0]     ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [31:0]                RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [32*C_REG_COUNT-1:0]  REG_OUT,
  output logic [C_REG_COUNT-1:0]     REG_WE
);

  localparam int unsigned IDX_W = C_ADDR_BITS - 2;

`ifdef TESTDRIVE_AXIL_REG_BANK_SLVERR_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  // ---------------- write path ----------------
  w_state_t          w_state, w_state_nxt;
  logic              awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0]        bresp_nxt;
  logic              aw_hs, w_hs, commit_c;
  logic [IDX_W-1:0]  aw_idx_q, w_idx_c;
  logic [31:0]       wdata_q, wdata_c;
  logic [3:0]        wstrb_q, wstrb_c;
  logic              w_in_range_c;
  logic [32*C_REG_COUNT-1:0] reg_q;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;

  // Commit uses the live channel value when its handshake lands this cycle.
  assign w_idx_c      = aw_hs ? AWADDR[C_ADDR_BITS-1:2] : aw_idx_q;
  assign wdata_c      = w_hs ? WDATA : wdata_q;
  assign wstrb_c      = w_hs ? WSTRB : wstrb_q;
  assign w_in_range_c = (32'(w_idx_c) < C_REG_COUNT);

  // Write FSM next-state and registered-output values.
  always_comb begin
    w_state_nxt = w_state;
    awready_nxt = 1'b0;
    wready_nxt  = 1'b0;
    bvalid_nxt  = 1'b0;
    bresp_nxt   = BRESP;
    commit_c    = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit_c    = 1'b1;
          w_state_nxt = W_RESP;
        end else if (aw_hs) begin
          w_state_nxt = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_state_nxt = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: if (w_hs) begin
        commit_c    = 1'b1;
        w_state_nxt = W_RESP;
      end
      W_HAVE_DATA: if (aw_hs) begin
        commit_c    = 1'b1;
        w_state_nxt = W_RESP;
      end
      W_RESP: if (BREADY && BVALID) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
    if (commit_c) bresp_nxt = w_in_range_c ? RESP_OKAY : OOR_RESP;
    case (w_state_nxt)
      W_IDLE:      begin awready_nxt = 1'b1; wready_nxt = 1'b1; end
      W_HAVE_ADDR: wready_nxt  = 1'b1;
      W_HAVE_DATA: awready_nxt = 1'b1;
      W_RESP:      bvalid_nxt  = 1'b1;
      default:     ;
    endcase
  end

  // Write FSM state and handshake outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
    end else begin
      w_state <= w_state_nxt;
      AWREADY <= awready_nxt;
      WREADY  <= wready_nxt;
      BVALID  <= bvalid_nxt;
      BRESP   <= bresp_nxt;
    end
  end

  // Hold whichever half of the write arrived first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= AWADDR[C_ADDR_BITS-1:2];
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
    end
  end

  // Register array with byte strobes; REG_WE pulses even for WSTRB=0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reg_q  <= '0;
      REG_WE <= '0;
    end else begin
      REG_WE <= '0;
      for (int i = 0; i < int'(C_REG_COUNT); i++) begin
        if (commit_c && w_in_range_c && (w_idx_c == IDX_W'(i))) begin
          REG_WE[i] <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (wstrb_c[b]) reg_q[32*i+8*b +: 8] <= wdata_c[8*b +: 8];
          end
        end
      end
    end
  end

  assign REG_OUT = reg_q;

  // ---------------- read path ----------------
  r_state_t          r_state, r_state_nxt;
  logic              arready_nxt, rvalid_nxt;
  logic [31:0]       rdata_nxt, rd_word_c;
  logic [1:0]        rresp_nxt;
  logic              ar_hs, r_in_range_c;
  logic [IDX_W-1:0]  r_idx_c;

  assign ar_hs        = ARVALID & ARREADY;
  assign r_idx_c      = ARADDR[C_ADDR_BITS-1:2];
  assign r_in_range_c = (32'(r_idx_c) < C_REG_COUNT);

  // Read mux over pre-write register state; out-of-range yields zero.
  always_comb begin
    rd_word_c = '0;
    for (int i = 0; i < int'(C_REG_COUNT); i++) begin
      if (r_idx_c == IDX_W'(i)) rd_word_c = reg_q[32*i +: 32];
    end
  end

  // Read FSM next-state and registered-output values.
  always_comb begin
    r_state_nxt = r_state;
    arready_nxt = 1'b0;
    rvalid_nxt  = 1'b0;
    rdata_nxt   = RDATA;
    rresp_nxt   = RRESP;
    case (r_state)
      R_IDLE: if (ar_hs) begin
        r_state_nxt = R_DATA;
        rdata_nxt   = rd_word_c;
        rresp_nxt   = r_in_range_c ? RESP_OKAY : OOR_RESP;
      end
      R_DATA: if (RREADY && RVALID) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
    arready_nxt = (r_state_nxt == R_IDLE);
    rvalid_nxt  = (r_state_nxt == R_DATA);
  end

  // Read FSM state and outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      r_state <= r_state_nxt;
      ARREADY <= arready_nxt;
      RVALID  <= rvalid_nxt;
      RDATA   <= rdata_nxt;
      RRESP   <= rresp_nxt;
    end
  end

  // Byte-offset address bits carry no meaning for word registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

endmodule

// File: tb/tb_testdrive_axi4_lite_reg_bank.sv
// Directed self-checking bench for testdrive_axi4_lite_reg_bank.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_testdrive_axi4_lite_reg_bank;

  localparam int unsigned AB = 10;
  localparam int unsigned RC = 16;

`ifdef TESTDRIVE_AXIL_REG_BANK_SLVERR_EN
  localparam logic [31:0] EXP_OOR = 32'h2;
`else
  localparam logic [31:0] EXP_OOR = 32'h0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [AB-1:0]   awaddr, araddr;
  logic            awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [1:0]      bresp, rresp;
  logic [31:0]     rdata;
  logic [32*RC-1:0] reg_out;
  logic [RC-1:0]   reg_we;

  logic [32*RC-1:0] exp_out;
  int checks = 0;
  int errors = 0;

  testdrive_axi4_lite_reg_bank #(.C_ADDR_BITS(AB), .C_REG_COUNT(RC)) dut (
    .CLK(clk), .RST(rst),
    .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
    .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
    .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
    .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
    .REG_OUT(reg_out), .REG_WE(reg_we)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    checks++;
    assert (reg_out === exp_out) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, reg_out, exp_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    exp_out = '0;

    // Reset values
    step(); step();
    chk("rst_awready", 32'(awready), 32'h0);
    chk("rst_wready",  32'(wready),  32'h0);
    chk("rst_arready", 32'(arready), 32'h0);
    chk("rst_bvalid",  32'(bvalid),  32'h0);
    chk("rst_rvalid",  32'(rvalid),  32'h0);
    chk("rst_rdata",   rdata,        32'h0);
    chk("rst_reg_we",  32'(reg_we),  32'h0);
    chk_regs("rst_reg_out");
    rst = 1'b0;
    step();
    chk("idle_awready", 32'(awready), 32'h1);
    chk("idle_wready",  32'(wready),  32'h1);
    chk("idle_arready", 32'(arready), 32'h1);

    // AW and W in the same cycle to reg2
    awaddr = 10'h008; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    exp_out[2*32 +: 32] = 32'hDEADBEEF;
    chk("w1_reg2",    reg_out[2*32 +: 32], 32'hDEADBEEF);
    chk("w1_reg_we",  32'(reg_we), 32'h0000_0004);
    chk("w1_bvalid",  32'(bvalid), 32'h1);
    chk("w1_bresp",   32'(bresp),  32'h0);
    chk("w1_awready", 32'(awready), 32'h0);
    step();
    chk("w1_we_pulse_end", 32'(reg_we), 32'h0);
    chk("w1_bvalid_hold",  32'(bvalid), 32'h1);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("w1_bvalid_done",  32'(bvalid), 32'h0);
    chk("w1_awready_back", 32'(awready), 32'h1);

    // Preload reg1 so the later single-byte write has other bytes to keep
    awaddr = 10'h004; wdata = 32'h11223344; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    step();
    bready = 1'b0;
    exp_out[1*32 +: 32] = 32'h11223344;
    chk("pre_reg1", reg_out[1*32 +: 32], 32'h11223344);

    // W three cycles ahead of AW: byte 0 of reg1 only
    wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("hd_awready", 32'(awready), 32'h1);
    chk("hd_wready",  32'(wready),  32'h0);
    step(); step();
    chk("hd_awready2", 32'(awready), 32'h1);
    chk("hd_wready2",  32'(wready),  32'h0);
    chk("hd_bvalid",   32'(bvalid),  32'h0);
    awaddr = 10'h004; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    exp_out[1*32 +: 32] = 32'h112233AA;
    chk("hd_reg1",   reg_out[1*32 +: 32], 32'h112233AA);
    chk("hd_reg_we", 32'(reg_we), 32'h0000_0002);
    chk("hd_bvalid_set", 32'(bvalid), 32'h1);
    bready = 1'b1;
    step();
    bready = 1'b0;

    // Read reg2 with RREADY held low for 5 cycles
    araddr = 10'h008; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rd_hold_rvalid",  32'(rvalid),  32'h1);
      chk("rd_hold_rdata",   rdata,        32'hDEADBEEF);
      chk("rd_hold_arready", 32'(arready), 32'h0);
      step();
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rd_done_rvalid",  32'(rvalid),  32'h0);
    chk("rd_done_arready", 32'(arready), 32'h1);

    // Write and read reg3 on the same edge: read sees the old value
    awaddr = 10'h00C; wdata = 32'h12345678; wstrb = 4'hF;
    araddr = 10'h00C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_out[3*32 +: 32] = 32'h12345678;
    chk("rw_rdata_old", rdata, 32'h0);
    chk("rw_rvalid",    32'(rvalid), 32'h1);
    chk("rw_reg3",      reg_out[3*32 +: 32], 32'h12345678);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("rw_rdata_new", rdata, 32'h12345678);
    chk("rw_rresp",     32'(rresp), 32'h0);
    rready = 1'b1;
    step();
    rready = 1'b0;

    // Out-of-range write and read at index 16
    awaddr = 10'h040; wdata = 32'hFFFFFFFF; wstrb = 4'hF; araddr = 10'h040;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("oor_bvalid", 32'(bvalid), 32'h1);
    chk("oor_bresp",  32'(bresp),  EXP_OOR);
    chk("oor_rresp",  32'(rresp),  EXP_OOR);
    chk("oor_rdata",  rdata,       32'h0);
    chk("oor_reg_we", 32'(reg_we), 32'h0);
    chk_regs("oor_regs");
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;

    // Reset while holding an address in W_HAVE_ADDR
    awaddr = 10'h010; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("ha_awready", 32'(awready), 32'h0);
    chk("ha_wready",  32'(wready),  32'h1);
    rst = 1'b1;
    #1;
    exp_out = '0;
    chk("mid_rst_awready", 32'(awready), 32'h0);
    chk("mid_rst_wready",  32'(wready),  32'h0);
    chk("mid_rst_bvalid",  32'(bvalid),  32'h0);
    chk("mid_rst_rdata",   rdata,        32'h0);
    chk_regs("mid_rst_regs");
    step();
    rst = 1'b0;
    step(); step();
    chk("post_rst_awready", 32'(awready), 32'h1);
    chk("post_rst_wready",  32'(wready),  32'h1);
    chk("post_rst_bvalid",  32'(bvalid),  32'h0);
    chk("post_rst_reg_we",  32'(reg_we),  32'h0);
    chk_regs("post_rst_regs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
